// File: rtl/cam_pkg.sv
// Shared constants and key type for the 8-entry content-addressable memory.
package cam_pkg;
  localparam int KEY_W_DEF = 8;
  localparam int DEPTH_DEF = 8;

  typedef logic [KEY_W_DEF-1:0] key_t;
endpackage

// File: rtl/cam_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of a match vector.
module cam_prio_enc #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  match,
  output logic [ADDR_W-1:0] index,
  output logic              any
);
  // Scan from the top down so the lowest matching index wins last.
  always_comb begin
    index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i] == 1'b1) index = ADDR_W'(i);
    end
    any = |match;
  end
endmodule

// File: rtl/cam_8x8.sv
// CAM with per-entry valid bits, single-cycle write and combinational search.
module cam_8x8
  import cam_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [KEY_W-1:0]  key,
  input  logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic              hit
);
  logic [DEPTH-1:0][KEY_W-1:0] r_entry;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            w_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry <= '0;
      r_valid <= '0;
    end else if (we) begin
      r_entry[waddr] <= key;
      r_valid[waddr] <= 1'b1;
    end
  end

  // Valid gates the compare so an X key cannot leak through an empty entry.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign w_match[g] = r_valid[g] & (r_entry[g] == key);
  end

  cam_prio_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prio (
    .match (w_match),
    .index (raddr),
    .any   (hit)
  );
endmodule

// File: tb/tb_cam_8x8.sv
// Directed bench for cam_8x8 with an expected-result scoreboard queue.
module tb_cam_8x8;
  import cam_pkg::*;

  typedef struct {
    logic       hit;
    logic [2:0] raddr;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       we;
  key_t       key;
  logic [2:0] waddr;
  logic [2:0] raddr;
  logic       hit;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  cam_8x8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .key   (key),
    .waddr (waddr),
    .raddr (raddr),
    .hit   (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input logic h, input logic [2:0] a, input string tag);
    exp_t e;
    e.hit = h; e.raddr = a; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (hit === e.hit && raddr === e.raddr)
    else begin
      failures++;
      $error("FAIL %s: hit=%b raddr=%0d, expected hit=%b raddr=%0d",
             e.tag, hit, raddr, e.hit, e.raddr);
    end
  endtask

  task automatic search(input key_t k, input logic h, input logic [2:0] a, input string tag);
    key = k;
    we  = 1'b0;
    expect_out(h, a, tag);
    #1;
    check_out();
  endtask

  task automatic write(input logic [2:0] a, input key_t k);
    @(negedge clk);
    we = 1'b1; waddr = a; key = k;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b1; waddr = 3'd0; key = 8'h00;
    // Write held across an edge while in reset must be dropped.
    @(posedge clk); #1;
    expect_out(1'b0, 3'd0, "in_reset");
    #1; check_out();
    @(negedge clk); #2;
    rst_n = 1'b1; we = 1'b0;
    search(8'h00, 1'b0, 3'd0, "reset_zero_key");
    key = 'x;
    expect_out(1'b0, 3'd0, "x_key_empty");
    #1; check_out();

    write(3'd0, 8'hAA);
    write(3'd1, 8'h55);
    search(8'hAA, 1'b1, 3'd0, "hit_aa");
    search(8'h55, 1'b1, 3'd1, "hit_55");
    search(8'hFF, 1'b0, 3'd0, "miss_ff");

    write(3'd5, 8'h3C);
    search(8'h3C, 1'b1, 3'd5, "single_3c");
    write(3'd2, 8'h3C);
    search(8'h3C, 1'b1, 3'd2, "prio_3c");

    // Pre-edge search must not see the value being written.
    @(negedge clk);
    we = 1'b1; waddr = 3'd3; key = 8'h77;
    expect_out(1'b0, 3'd0, "same_cycle_pre");
    #1; check_out();
    @(posedge clk); #1;
    we = 1'b0;
    search(8'h77, 1'b1, 3'd3, "same_cycle_post");

    write(3'd0, 8'h11);
    search(8'hAA, 1'b0, 3'd0, "overwrite_old");
    search(8'h11, 1'b1, 3'd0, "overwrite_new");
    search(8'h55, 1'b1, 3'd1, "untouched_55");

    write(3'd7, 8'hE1);
    search(8'hE1, 1'b1, 3'd7, "top_entry");

    // we=0 across an edge leaves storage alone.
    @(negedge clk);
    we = 1'b0; waddr = 3'd6; key = 8'hD0;
    @(posedge clk); #1;
    search(8'hD0, 1'b0, 3'd0, "no_write_we0");

    // Asynchronous reset between edges.
    search(8'h11, 1'b1, 3'd0, "pre_async_rst");
    @(posedge clk); #3;
    rst_n = 1'b0;
    expect_out(1'b0, 3'd0, "async_rst_now");
    #1; check_out();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    search(8'h11, 1'b0, 3'd0, "after_rst_11");
    search(8'h55, 1'b0, 3'd0, "after_rst_55");
    search(8'h00, 1'b0, 3'd0, "after_rst_00");
    write(3'd4, 8'h99);
    search(8'h99, 1'b1, 3'd4, "first_write_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
